// File: rtl/sync_ld_down_ctr_pkg.sv
// ============================================================================
// Module      : sync_ld_down_ctr_pkg
// Description : Shared state encodings and mode constants for the loadable
//               down-counter/timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_ld_down_ctr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sync_ld_down_ctr_if.sv
// ============================================================================
// Module      : sync_ld_down_ctr_if
// Description : Control/status bundle between a controller and the
//               down-counter/timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_ld_down_ctr_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] l_data;
    logic             mode;
    logic [WIDTH-1:0] ctr;
    logic             tc;
    logic             busy;

    modport master (
        output en,
        output load,
        output l_data,
        output mode,
        input  ctr,
        input  tc,
        input  busy
    );

    modport slave (
        input  en,
        input  load,
        input  l_data,
        input  mode,
        output ctr,
        output tc,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/sync_ld_down_ctr.sv
// ============================================================================
// Module      : sync_ld_down_ctr
// Description : Loadable synchronous down-counter/timer with one-shot or
//               auto-reload operation and a one-cycle terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ld_down_ctr
    import sync_ld_down_ctr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    sync_ld_down_ctr_if.slave     bus
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_ctr;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_ctr_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_ctr_nxt    = r_ctr;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;

        if (bus.load) begin
            w_ctr_nxt    = bus.l_data;
            w_reload_nxt = bus.l_data;
            if (bus.l_data != c_zero) begin
                w_state_nxt = ST_RUN;
            end else begin
                // A zero load from IDLE is an immediate terminal count; a
                // zero load while running simply stops without a pulse.
                w_state_nxt = ST_IDLE;
                w_tc_nxt    = (r_state == ST_IDLE);
            end
        end else if (r_state == ST_RUN && bus.en) begin
            if (r_ctr > c_one) begin
                w_ctr_nxt = r_ctr - c_one;
            end else if (r_ctr == c_one) begin
                w_tc_nxt = 1'b1;
                if (bus.mode == MODE_RELOAD) begin
                    w_ctr_nxt = r_reload;
                end else begin
                    w_ctr_nxt   = c_zero;
                    w_state_nxt = ST_IDLE;
                end
            end else begin
                // Defensive: never decrement through zero.
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ctr    <= c_zero;
            r_reload <= c_zero;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ctr    <= w_ctr_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
        end
    end

    assign bus.ctr  = r_ctr;
    assign bus.tc   = r_tc;
    assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sync_ld_down_ctr.sv
// ============================================================================
// Module      : tb_sync_ld_down_ctr
// Description : Directed self-checking bench for the loadable down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_ld_down_ctr;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sync_ld_down_ctr_if #(.WIDTH(4)) bus ();

    sync_ld_down_ctr #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.load = 1'b0; bus.en = 1'b0; bus.mode = 1'b0; bus.l_data = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.ctr !== 4'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: ctr=%0d tc=%b busy=%b, want ctr=0 tc=0 busy=0", bus.ctr, bus.tc, bus.busy);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.ctr !== 4'd0 || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin
                failures++;
                $display("FAIL idle_en[%0d]: ctr=%0d tc=%b busy=%b, want 0/0/0", i, bus.ctr, bus.tc, bus.busy);
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_oneshot();
        do_reset();
        bus.load = 1'b1; bus.l_data = 4'd5; bus.mode = 1'b0; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.ctr !== 4'd5 || bus.busy !== 1'b1 || bus.tc !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_load: ctr=%0d tc=%b busy=%b, want 5/0/1", bus.ctr, bus.tc, bus.busy);
        end
        for (int i = 1; i <= 5; i++) begin
            logic [3:0] e_ctr;
            logic       e_tc;
            logic       e_busy;
            tick();
            e_ctr  = 4'(5 - i);
            e_tc   = (i == 5);
            e_busy = (i != 5);
            checks++;
            if (bus.ctr !== e_ctr || bus.tc !== e_tc || bus.busy !== e_busy) begin
                failures++;
                $display("FAIL oneshot[%0d]: ctr=%0d tc=%b busy=%b, want %0d/%b/%b",
                         i, bus.ctr, bus.tc, bus.busy, e_ctr, e_tc, e_busy);
            end
        end
        tick();
        checks++;
        if (bus.ctr !== 4'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_after: ctr=%0d tc=%b busy=%b, want 0/0/0", bus.ctr, bus.tc, bus.busy);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_autoreload();
        logic [3:0] seq [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
        do_reset();
        bus.load = 1'b1; bus.l_data = 4'd3; bus.mode = 1'b1; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.ctr !== 4'd3 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reload_load: ctr=%0d busy=%b, want 3/1", bus.ctr, bus.busy);
        end
        for (int i = 0; i < 9; i++) begin
            logic e_tc;
            tick();
            e_tc = (seq[i] == 4'd3);
            checks++;
            if (bus.ctr !== seq[i] || bus.tc !== e_tc || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL reload[%0d]: ctr=%0d tc=%b busy=%b, want %0d/%b/1",
                         i, bus.ctr, bus.tc, bus.busy, seq[i], e_tc);
            end
        end
        bus.en = 1'b0;
        bus.mode = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        bus.load = 1'b1; bus.l_data = 4'd6; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.ctr !== 4'd4) begin
            failures++;
            $display("FAIL pause_pre: ctr=%0d, want 4", bus.ctr);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.ctr !== 4'd4 || bus.busy !== 1'b1 || bus.tc !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold[%0d]: ctr=%0d tc=%b busy=%b, want 4/0/1", i, bus.ctr, bus.tc, bus.busy);
            end
        end
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.ctr !== 4'd3) begin
            failures++;
            $display("FAIL pause_resume: ctr=%0d, want 3", bus.ctr);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_reload_midrun();
        do_reset();
        bus.load = 1'b1; bus.l_data = 4'd4; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.ctr !== 4'd2) begin
            failures++;
            $display("FAIL midrun_pre: ctr=%0d, want 2", bus.ctr);
        end
        bus.load = 1'b1; bus.l_data = 4'd9;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.ctr !== 4'd9 || bus.tc !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_load: ctr=%0d tc=%b busy=%b, want 9/0/1", bus.ctr, bus.tc, bus.busy);
        end
        tick();
        tick();
        checks++;
        if (bus.ctr !== 4'd7 || bus.tc !== 1'b0) begin
            failures++;
            $display("FAIL midrun_cont: ctr=%0d tc=%b, want 7/0", bus.ctr, bus.tc);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_edge_cases();
        do_reset();
        bus.load = 1'b1; bus.l_data = 4'd0;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.ctr !== 4'd0 || bus.tc !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_load: ctr=%0d tc=%b busy=%b, want 0/1/0", bus.ctr, bus.tc, bus.busy);
        end
        tick();
        checks++;
        if (bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_load_after: tc=%b busy=%b, want 0/0", bus.tc, bus.busy);
        end
        // Bring count to 1 so the next edge would be terminal, then reset with load.
        bus.load = 1'b1; bus.l_data = 4'd2; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        checks++;
        if (bus.ctr !== 4'd1) begin
            failures++;
            $display("FAIL edge_pre: ctr=%0d, want 1", bus.ctr);
        end
        rst = 1'b1; bus.load = 1'b1; bus.l_data = 4'd7;
        tick();
        rst = 1'b0; bus.load = 1'b0;
        checks++;
        if (bus.ctr !== 4'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_and_load: ctr=%0d tc=%b busy=%b, want 0/0/0", bus.ctr, bus.tc, bus.busy);
        end
        tick();
        checks++;
        if (bus.ctr !== 4'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_after: ctr=%0d tc=%b busy=%b, want 0/0/0", bus.ctr, bus.tc, bus.busy);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.l_data = 4'd0; bus.mode = 1'b0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_reload_midrun();
        test_edge_cases();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
